// File: rtl/clk_div_multi_if.sv
// Control and status bundle for the multi-channel clock divider.
// The master side drives enables, factors, load strobes and sync_clear.
interface clk_div_multi_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS*WIDTH-1:0] div_factor;
  logic [CHANNELS-1:0]       load;
  logic                      sync_clear;
  logic [CHANNELS-1:0]       clk_out;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       busy;

  modport master (
    output enable, div_factor, load, sync_clear,
    input  clk_out, tick, busy
  );

  modport slave (
    input  enable, div_factor, load, sync_clear,
    output clk_out, tick, busy
  );
endinterface

// File: rtl/clk_div_multi.sv
// CHANNELS independent 50%-duty dividers (period 2*N) with a tick on every edge,
// glitch-free factor reload at half-period boundaries and a common sync_clear.

module clk_div_lane #(
  parameter int WIDTH     = 32,
  parameter int RESET_DIV = 1
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             sync_clear,
  input  logic [WIDTH-1:0] div_factor,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] fac;
  logic             term;

  // active_q never drops below 1, so active_q-1 cannot wrap
  always_comb begin
    fac  = (div_factor == '0) ? ONE : div_factor;
    term = enable && (count_q >= active_q - ONE);
  end

  always_comb begin
    count_d   = count_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;

    if (load) shadow_d = fac;

    if (sync_clear) begin
      count_d   = '0;
      clk_out_d = 1'b0;
      pending_d = 1'b0;
      if (load)           active_d = fac;
      else if (pending_q) active_d = shadow_q;
    end else if (term) begin
      count_d   = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = 1'b1;
      pending_d = 1'b0;
      if (load)           active_d = fac;
      else if (pending_q) active_d = shadow_q;
    end else if (enable) begin
      // mid half-period: new factor waits for the next boundary
      count_d = count_q + ONE;
      if (load) pending_d = 1'b1;
    end else if (load) begin
      active_d  = fac;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      active_q  <= RST_DIV;
      shadow_q  <= RST_DIV;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign busy    = pending_q;
endmodule

module clk_div_multi #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 2,
  parameter int RESET_DIV = 1
) (
  input logic             clk_50,
  input logic             reset,
  clk_div_multi_if.slave  bus
);
  logic [CHANNELS-1:0] clk_out_w;
  logic [CHANNELS-1:0] tick_w;
  logic [CHANNELS-1:0] busy_w;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    clk_div_lane #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_lane (
      .clk_50     (clk_50),
      .reset      (reset),
      .enable     (bus.enable[c]),
      .load       (bus.load[c]),
      .sync_clear (bus.sync_clear),
      .div_factor (bus.div_factor[c*WIDTH +: WIDTH]),
      .clk_out    (clk_out_w[c]),
      .tick       (tick_w[c]),
      .busy       (busy_w[c])
    );
  end

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;
  assign bus.busy    = busy_w;
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed + random checks of clk_div_multi against a half-period reference model.
module tb_clk_div_multi;
  localparam int W  = 32;
  localparam int CH = 2;
  localparam int RD = 1;

  logic          clk_50 = 1'b0;
  logic          reset  = 1'b1;
  logic [CH-1:0] en     = '0;
  logic [CH-1:0] ld     = '0;
  logic [CH*W-1:0] df   = '0;
  logic          sc     = 1'b0;

  clk_div_multi_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
  assign bus.enable     = en;
  assign bus.load       = ld;
  assign bus.div_factor = df;
  assign bus.sync_clear = sc;

  clk_div_multi #(.WIDTH(W), .CHANNELS(CH), .RESET_DIV(RD)) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_50 = ~clk_50;

  // Model: each channel is a sequence of half-periods; track length, cycles spent,
  // the output level, and an optional queued next length.
  int m_half [CH];
  int m_spent[CH];
  int m_next [CH];
  bit m_has  [CH];
  bit m_lvl  [CH];
  bit m_tk   [CH];

  int errors = 0;
  int checks = 0;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_half[c] = RD; m_spent[c] = 0; m_next[c] = RD;
      m_has[c] = 0; m_lvl[c] = 0; m_tk[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < CH; c++) begin
      int f;
      f = int'(df[c*W +: W]);
      if (f == 0) f = 1;
      m_tk[c] = 0;
      if (sc) begin
        m_spent[c] = 0; m_lvl[c] = 0;
        if (ld[c]) m_half[c] = f;
        else if (m_has[c]) m_half[c] = m_next[c];
        m_has[c] = 0;
      end else if (en[c]) begin
        if (m_spent[c] + 1 >= m_half[c]) begin
          m_lvl[c] = !m_lvl[c]; m_tk[c] = 1; m_spent[c] = 0;
          if (ld[c]) m_half[c] = f;
          else if (m_has[c]) m_half[c] = m_next[c];
          m_has[c] = 0;
        end else begin
          m_spent[c]++;
          if (ld[c]) begin m_next[c] = f; m_has[c] = 1; end
        end
      end else if (ld[c]) begin
        m_half[c] = f; m_has[c] = 0;
      end
    end
  endfunction

  task automatic check_outs(input string tag);
    logic [CH-1:0] e_clk, e_tk, e_bsy;
    for (int c = 0; c < CH; c++) begin
      e_clk[c] = m_lvl[c]; e_tk[c] = m_tk[c]; e_bsy[c] = m_has[c];
    end
    checks += 3;
    assert (bus.clk_out === e_clk) else begin
      errors++; $error("FAIL %s clk_out got %b want %b", tag, bus.clk_out, e_clk);
    end
    assert (bus.tick === e_tk) else begin
      errors++; $error("FAIL %s tick got %b want %b", tag, bus.tick, e_tk);
    end
    assert (bus.busy === e_bsy) else begin
      errors++; $error("FAIL %s busy got %b want %b", tag, bus.busy, e_bsy);
    end
  endtask

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++; $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk_50);
    model_step();
    #1;
    check_outs("cycle");
  endtask

  // steps until channel c ticks; 64-step bound keeps the run finite
  task automatic wait_tick(input int c, output int n);
    n = 0;
    do begin step(); n++; end while (!bus.tick[c] && n < 64);
  endtask

  task automatic set_div(input int c, input int v);
    df[c*W +: W] = W'(v);
  endtask

  initial begin
    int n;
    logic held;
    model_reset();
    #2;
    check_outs("reset");
    reset = 1'b0;

    // ch0 N=4, ch1 N=1 loaded while idle
    en = '0; ld = 2'b11; set_div(0, 4); set_div(1, 1);
    step();
    ld = '0; en = 2'b11;
    wait_tick(0, n); wait_tick(0, n);
    chk("ch0_half4", n, 4);
    wait_tick(1, n);
    chk("ch1_half1", n, 1);

    // zero factor behaves as N=1
    en[0] = 0; ld = 2'b01; set_div(0, 0);
    step();
    ld = '0; en[0] = 1;
    wait_tick(0, n); wait_tick(0, n);
    chk("zero_half", n, 1);

    // mid-period reload 5 -> 2
    en[0] = 0; ld = 2'b01; set_div(0, 5);
    step();
    ld = '0; en[0] = 1;
    wait_tick(0, n);
    step(); step();
    set_div(0, 2); ld = 2'b01;
    step();
    ld = '0;
    chk("reload_busy", bus.busy[0], 1);
    wait_tick(0, n);
    chk("reload_old_half", 3 + n, 5);
    chk("reload_busy_clr", bus.busy[0], 0);
    wait_tick(0, n);
    chk("reload_new_half", n, 2);

    // load on the terminal cycle goes straight to active
    en[0] = 0; ld = 2'b01; set_div(0, 3);
    step();
    ld = '0; en[0] = 1;
    wait_tick(0, n);
    step(); step();
    set_div(0, 6); ld = 2'b01;
    step();
    ld = '0;
    chk("term_load_tick", bus.tick[0], 1);
    chk("term_load_busy", bus.busy[0], 0);
    wait_tick(0, n);
    chk("term_load_half", n, 6);

    // enable gating at count=2
    en[0] = 0; ld = 2'b01; set_div(0, 4);
    step();
    ld = '0; en[0] = 1;
    wait_tick(0, n);
    step(); step();
    en[0] = 0; held = bus.clk_out[0];
    repeat (10) begin
      step();
      chk("gate_hold", bus.clk_out[0], held);
    end
    en[0] = 1;
    wait_tick(0, n);
    chk("gate_resume", n, 2);

    // sync_clear applies ch1 pending load and phase-aligns
    en = '0; ld = 2'b11; set_div(0, 3); set_div(1, 5);
    step();
    ld = '0; en = 2'b11;
    step(); step();
    set_div(1, 3); ld = 2'b10;
    step();
    ld = '0;
    chk("sc_pending", bus.busy[1], 1);
    sc = 1;
    step();
    sc = 0;
    chk("sc_clk", bus.clk_out, 0);
    chk("sc_busy", bus.busy, 0);
    wait_tick(1, n);
    chk("sc_new_active", n, 3);
    repeat (12) begin
      step();
      chk("in_phase", bus.clk_out[0], bus.clk_out[1]);
    end

    // random traffic
    repeat (400) begin
      en = CH'($urandom);
      for (int c = 0; c < CH; c++) begin
        ld[c] = ($urandom_range(0, 5) == 0);
        set_div(c, $urandom_range(0, 6));
      end
      sc = ($urandom_range(0, 39) == 0);
      step();
    end
    ld = '0; sc = 0;

    // async reset between edges
    en = 2'b11;
    step();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_outs("async_reset");
    #2;
    reset = 1'b0;
    wait_tick(0, n);
    chk("first_tick_after_reset", n, RD);
    wait_tick(0, n);
    chk("reset_div_half", n, RD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parametrised multi-channel successor to the single-channel 50 MHz clock divider. Each of CHANNELS independent dividers produces a 50%-duty square wave and a one-cycle tick pulse at every output edge. Divide factors are reloaded glitch-free at half-period boundaries. A common sync_clear phase-aligns all channels. Sits beside the audio/sample-rate and display timing logic, driven from clk_50.

Parameters:
WIDTH, 32, bit width of each divide factor and counter.
CHANNELS, 2, number of independent divider channels.
RESET_DIV, 1, active divide factor of every channel after reset; must be >= 1.

Ports:
clk_50  input  1  system clock, 50 MHz; all logic on posedge.
reset  input  1  asynchronous, active-high reset.
enable  input  CHANNELS  per-channel run enable; low freezes that channel.
div_factor  input  CHANNELS*WIDTH  per-channel requested factor N; channel c occupies bits [c*WIDTH +: WIDTH].
load  input  CHANNELS  per-channel strobe: capture div_factor slice into shadow register.
sync_clear  input  1  synchronous clear of all counters and outputs; applies pending loads.
clk_out  output  CHANNELS  divided clocks; output period = 2*N clk_50 cycles, 50% duty.
tick  output  CHANNELS  one-cycle pulse in the same cycle clk_out toggles.
busy  output  CHANNELS  high while a captured load is pending, not yet active.

Behaviour:
- Reset (async, reset=1): count=0, active=RESET_DIV, shadow=RESET_DIV, pending=0, clk_out=0, tick=0, busy=0 on all channels. Effective immediately, independent of clk_50.
- Factor sanitising: a captured value of 0 is stored as 1. No underflow; N=0 and N=1 both give period 2 cycles.
- Terminal condition per channel: enable=1 and count >= active-1. The >= comparison is a robustness guard.
- Enabled, non-terminal cycle: count <= count+1; tick=0; clk_out unchanged.
- Terminal cycle: count <= 0; clk_out toggles; tick=1 for exactly that cycle (registered, aligned with the clk_out edge). If pending=1, active <= shadow and pending clears.
- Load handling: load=1 captures the sanitised slice into shadow and sets pending.
  - Load while enable=1 on a non-terminal cycle: the new value waits for the next terminal cycle. The half-period in progress completes at the old rate.
  - Load on the same cycle as a terminal: the new value goes straight to active, pending stays 0, and the next half-period uses the new N.
  - Load while enable=0: active <= sanitised value immediately, pending=0.
  - Repeated loads before application: the last value wins.
- enable=0: count, clk_out and active hold; tick=0. Resuming continues mid-period from the held count, with no extra edge.
- sync_clear=1: all channels get count=0, clk_out=0, tick=0; any pending shadow is applied to active and pending clears. sync_clear has priority over load and terminal in the same cycle. A load asserted alongside sync_clear is applied as the new active value.
- busy = pending (registered).
- Frequency: f_out = 50 MHz / (2*N). There is no combinational path from inputs to outputs.
- Reset asserted mid-period returns the channel to the reset state asynchronously. The first tick after release occurs RESET_DIV cycles after the first enabled edge.

Test Plan:
- Reset and run: CHANNELS=2, loads with enable=0 of ch0 N=4 and ch1 N=1, then enable=11. ch0 clk_out toggles every 4 cycles (period 8), ch1 every cycle (period 2). tick pulses align with each toggle. Duty is exactly 50%.
- Zero factor: load N=0 on ch0 with enable=0, then enable. Period is 2 cycles, same as N=1. No stuck output, count never exceeds 0.
- Mid-period reload: ch0 running N=5; load N=2 two cycles after a toggle. busy=1 until the next terminal; that half-period still lasts 5 cycles; subsequent half-periods last 2 cycles; busy returns to 0 on the terminal cycle.
- Load coinciding with terminal: ch0 N=3; load N=6 on the terminal cycle. The very next half-period is 6 cycles and busy never asserts.
- Enable gating: ch0 N=4, drop enable for 10 cycles at count=2. clk_out and count freeze with tick=0. On resume, the next toggle occurs 2 cycles later.
- sync_clear and async reset: both channels at different phases with a pending load on ch1; pulse sync_clear. Both clk_out are 0 and count=0, ch1 active equals the shadow value, and outputs are in phase afterwards. Assert reset between clock edges: outputs clear immediately and active returns to RESET_DIV.
